// File: rtl/aes256_dec.sv
// Iterative AES-256 inverse cipher: 7-cycle key expansion, 1 whitening cycle, 14 inverse rounds.
// Latency 22 cycles from accept edge to done; start is ignored unless IDLE (no queueing).
module aes256_dec (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [127:0] in,
  output logic [127:0] out,
  output logic         busy,
  output logic         done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KEXP   = 3'd1;
  localparam logic [2:0] S_WHITEN = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and conveniently maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  logic [2:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [255:0] kw_q, kw_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] out_q, out_d;
  logic [127:0] rk_q [0:14];

  // One key-schedule step: eight new words from the previous eight.
  logic [7:0]   rcon;
  logic [31:0]  n0, n1, n2, n3, n4, n5, n6, n7;
  logic [255:0] kw_next;

  assign rcon = 8'h01 << (cnt_q - 4'd1);
  assign n0 = kw_q[255:224] ^ sub_word({kw_q[23:0], kw_q[31:24]}) ^ {rcon, 24'h000000};
  assign n1 = kw_q[223:192] ^ n0;
  assign n2 = kw_q[191:160] ^ n1;
  assign n3 = kw_q[159:128] ^ n2;
  assign n4 = kw_q[127:96]  ^ sub_word(n3);
  assign n5 = kw_q[95:64]   ^ n4;
  assign n6 = kw_q[63:32]   ^ n5;
  assign n7 = kw_q[31:0]    ^ n6;
  assign kw_next = {n0, n1, n2, n3, n4, n5, n6, n7};

  logic [127:0] round_out;

  always_comb begin
    logic [7:0]   b [16];
    logic [127:0] rk;
    logic [127:0] ark;
    logic [127:0] mix;
    rk  = rk_q[cnt_q];
    ark = '0;
    mix = '0;
    for (int i = 0; i < 16; i++) b[i] = blk_q[127-8*i -: 8];
    // Row r of the inverse-shifted state takes column (c - r) mod 4 of the current state.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ark[127-8*(r+4*c) -: 8] = inv_sbox(b[r+4*((c-r+4)%4)]) ^ rk[127-8*(r+4*c) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) mix[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    round_out = (cnt_q == 4'd0) ? ark : mix;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kw_d    = kw_q;
    blk_d   = blk_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_KEXP;
          cnt_d   = 4'd1;
          kw_d    = key;
          blk_d   = in;
        end
      end
      S_KEXP: begin
        kw_d = kw_next;
        if (cnt_q == 4'd7) state_d = S_WHITEN;
        else               cnt_d   = cnt_q + 4'd1;
      end
      S_WHITEN: begin
        blk_d   = blk_q ^ rk_q[14];
        state_d = S_ROUND;
        cnt_d   = 4'd13;
      end
      S_ROUND: begin
        blk_d = round_out;
        if (cnt_q == 4'd0) begin
          out_d   = round_out;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      kw_q    <= '0;
      blk_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kw_q    <= kw_d;
      blk_q   <= blk_d;
      out_q   <= out_d;
    end
  end

  // Step k writes rk[2k] and rk[2k+1]; the last step's upper half (w60..63) is unused.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      rk_q[0] <= key[255:128];
      rk_q[1] <= key[127:0];
    end else if (state_q == S_KEXP) begin
      rk_q[{cnt_q[2:0], 1'b0}] <= kw_next[255:128];
      if (cnt_q != 4'd7) rk_q[{cnt_q[2:0], 1'b1}] <= kw_next[127:0];
    end
  end

  assign out  = out_q;
  assign busy = (state_q == S_KEXP) || (state_q == S_WHITEN) || (state_q == S_ROUND);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_aes256_dec.sv
// Directed and round-trip bench for aes256_dec; an independent AES-256 encrypt model supplies ciphertexts.
module tb_aes256_dec;

  localparam logic [255:0] K_C3    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C3   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT_ZERO = 128'hdc95c078a2408989ad48a21492842087;

  logic         clk;
  logic         rst;
  logic         start;
  logic [255:0] key;
  logic [127:0] in_dat;
  logic [127:0] out_dat;
  logic         busy;
  logic         done;

  int checks;
  int failures;

  logic [7:0] sbox_t [256];

  aes256_dec dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .key   (key),
    .in    (in_dat),
    .out   (out_dat),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box table from a brute-force inverse search plus the bitwise affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [255:0] k, input logic [127:0] p);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 14; r++) begin
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*c] = sbox_t[s[rr+4*((c+rr)%4)]];
      for (int c = 0; c < 4; c++) begin
        if (r < 14) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end else begin
          for (int i = 0; i < 4; i++) s[4*c+i] = t[4*c+i];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Runs one block with a single-cycle start; lat=-1 if done never arrives.
  task automatic run_block(input logic [255:0] k, input logic [127:0] ct,
                           output logic [127:0] pt, output int lat, output bit stable);
    logic [127:0] prev;
    prev   = out_dat;
    stable = 1'b1;
    lat    = -1;
    pt     = 'x;
    key    = k;
    in_dat = ct;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (done) begin
        lat = e;
        pt  = out_dat;
        break;
      end
      if (out_dat !== prev) stable = 1'b0;
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    key = '0;
    in_dat = '0;
    tick();
    tick();
    checks++; if (out_dat !== 128'h0) begin failures++; $display("FAIL reset_out got=%h want=0", out_dat); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    rst = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL idle_quiet busy=%b done=%b want=0,0", busy, done);
    end
  endtask

  task automatic test_all_zero();
    logic [127:0] pt;
    int lat;
    bit stable;
    run_block('0, CT_ZERO, pt, lat, stable);
    checks++; if (lat !== 22) begin failures++; $display("FAIL zero_latency got=%0d want=22", lat); end
    checks++; if (pt !== 128'h0) begin failures++; $display("FAIL zero_out got=%h want=0", pt); end
  endtask

  task automatic test_c3();
    int lat;
    int busy_cnt;
    key = K_C3;
    in_dat = CT_C3;
    start = 1'b1;
    tick();
    start = 1'b0;
    key = '1;
    in_dat = '1;
    lat = -1;
    busy_cnt = busy ? 1 : 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (done) begin
        lat = e;
        break;
      end
      if (busy) busy_cnt++;
    end
    checks++; if (lat !== 22) begin failures++; $display("FAIL c3_latency got=%0d want=22", lat); end
    checks++; if (busy_cnt !== 22) begin failures++; $display("FAIL c3_busy_cycles got=%0d want=22", busy_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL c3_busy_in_done got=%b want=0", busy); end
    checks++; if (out_dat !== PT_C3) begin failures++; $display("FAIL c3_out got=%h want=%h", out_dat, PT_C3); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL c3_done_width got=%b want=0", done); end
    checks++; if (out_dat !== PT_C3) begin failures++; $display("FAIL c3_out_hold got=%h want=%h", out_dat, PT_C3); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] pt;
    int lat;
    int late_done;
    bit stable;
    key = K_C3;
    in_dat = CT_C3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 10; e++) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b want=1", busy); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_dat !== 128'h0) begin failures++; $display("FAIL mid_rst_out got=%h want=0", out_dat); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL mid_rst_flags busy=%b done=%b want=0,0", busy, done);
    end
    tick();
    rst = 1'b0;
    late_done = 0;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (done) late_done++;
    end
    checks++; if (late_done !== 0) begin failures++; $display("FAIL mid_no_done got=%0d want=0", late_done); end
    run_block(K_C3, CT_C3, pt, lat, stable);
    checks++; if (lat !== 22) begin failures++; $display("FAIL mid_restart_latency got=%0d want=22", lat); end
    checks++; if (pt !== PT_C3) begin failures++; $display("FAIL mid_restart_out got=%h want=%h", pt, PT_C3); end
  endtask

  task automatic test_back_to_back();
    int lat;
    key = K_C3;
    in_dat = CT_C3;
    start = 1'b1;
    tick();
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e == 5) begin
        in_dat = {$urandom(), $urandom(), $urandom(), $urandom()};
        key    = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (done) begin
        lat = e;
        break;
      end
    end
    checks++; if (lat !== 22) begin failures++; $display("FAIL held_latency got=%0d want=22", lat); end
    checks++; if (out_dat !== PT_C3) begin failures++; $display("FAIL held_out got=%h want=%h", out_dat, PT_C3); end
    key = '0;
    in_dat = CT_ZERO;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL held_idle_gap busy=%b done=%b want=0,0", busy, done);
    end
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL held_second_start got=%b want=1", busy); end
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (done) begin
        lat = e;
        break;
      end
    end
    checks++; if (lat !== 22) begin failures++; $display("FAIL held2_latency got=%0d want=22", lat); end
    checks++; if (out_dat !== 128'h0) begin failures++; $display("FAIL held2_out got=%h want=0", out_dat); end
    tick();
  endtask

  task automatic test_round_trip();
    logic [255:0] k;
    logic [127:0] p;
    logic [127:0] ct;
    logic [127:0] got;
    int lat;
    bit stable;
    checks++; if (aes_enc(K_C3, PT_C3) !== CT_C3) begin
      failures++; $display("FAIL model_c3 got=%h want=%h", aes_enc(K_C3, PT_C3), CT_C3);
    end
    for (int n = 0; n < 1000; n++) begin
      k  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      p  = {$urandom(), $urandom(), $urandom(), $urandom()};
      ct = aes_enc(k, p);
      run_block(k, ct, got, lat, stable);
      checks++; if (lat !== 22 || got !== p) begin
        failures++; $display("FAIL rt_out n=%0d lat=%0d got=%h want=%h", n, lat, got, p);
      end
      checks++; if (!stable) begin
        failures++; $display("FAIL rt_out_stable n=%0d changed=1 want=0", n);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    key = '0;
    in_dat = '0;
    build_sbox();
    test_reset();
    test_all_zero();
    test_c3();
    test_reset_mid();
    test_back_to_back();
    test_round_trip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
